// File: rtl/posit_sign_inject_pipe.sv
// Pipelined posit sign injection: SGNJ / SGNJN / SGNJX / MV with ready/valid.
// Optional flags_o (NaR, negated) when POSIT_SGNJ_FLAGS_EN is defined.
module posit_sign_inject_pipe #(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 1,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     posit_a_i,
    input  logic [WIDTH-1:0]     posit_b_i,
    input  logic [1:0]           op_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     posit_o,
`ifdef POSIT_SGNJ_FLAGS_EN
    output logic [1:0]           flags_o,
`endif
    output logic [TAG_WIDTH-1:0] tag_o
);

    logic             w_sa;
    logic             w_sb;
    logic             w_t;
    logic             w_zero;
    logic             w_nar;
    logic             w_neg;
    logic [WIDTH-1:0] w_res;

    assign w_sa   = posit_a_i[WIDTH-1];
    assign w_sb   = posit_b_i[WIDTH-1];
    assign w_zero = ~|posit_a_i;
    assign w_nar  = posit_a_i[WIDTH-1] & ~|posit_a_i[WIDTH-2:0];

    always_comb begin
        w_t = w_sa;
        unique case (op_i)
            2'b00: w_t = w_sb;
            2'b01: w_t = ~w_sb;
            2'b10: w_t = w_sa ^ w_sb;
            2'b11: w_t = w_sa;
        endcase
    end

    // Zero and NaR are their own negation, so they pass through untouched.
    assign w_neg = ~w_zero & ~w_nar & (w_sa ^ w_t);
    assign w_res = w_neg ? (~posit_a_i + {{(WIDTH-1){1'b0}}, 1'b1})
                         : posit_a_i;

    logic [STAGES-1:0]    r_vld;
    logic [WIDTH-1:0]     r_dat [STAGES];
    logic [TAG_WIDTH-1:0] r_tag [STAGES];
    logic [STAGES-1:0]    w_adv;
    logic [STAGES-1:0]    w_src_vld;
    logic [WIDTH-1:0]     w_src_dat [STAGES];
    logic [TAG_WIDTH-1:0] w_src_tag [STAGES];
`ifdef POSIT_SGNJ_FLAGS_EN
    logic [1:0]           r_flg [STAGES];
    logic [1:0]           w_src_flg [STAGES];
`endif

    // Stage k may move when the output drains or any later stage has a hole.
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign w_adv[k] = out_ready_i | ~(&r_vld[STAGES-1:k]);
    end

    always_comb begin
        w_src_vld[0] = in_valid_i;
        w_src_dat[0] = w_res;
        w_src_tag[0] = tag_i;
`ifdef POSIT_SGNJ_FLAGS_EN
        w_src_flg[0] = {w_neg, w_nar};
`endif
        for (int k = 1; k < STAGES; k++) begin
            w_src_vld[k] = r_vld[k-1];
            w_src_dat[k] = r_dat[k-1];
            w_src_tag[k] = r_tag[k-1];
`ifdef POSIT_SGNJ_FLAGS_EN
            w_src_flg[k] = r_flg[k-1];
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_dat[k] <= '0;
                r_tag[k] <= '0;
`ifdef POSIT_SGNJ_FLAGS_EN
                r_flg[k] <= '0;
`endif
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush_i) begin
                    r_vld[k] <= 1'b0;
                end else if (w_adv[k]) begin
                    r_vld[k] <= w_src_vld[k];
                end
                if (w_adv[k] && w_src_vld[k] && !flush_i) begin
                    r_dat[k] <= w_src_dat[k];
                    r_tag[k] <= w_src_tag[k];
`ifdef POSIT_SGNJ_FLAGS_EN
                    r_flg[k] <= w_src_flg[k];
`endif
                end
            end
        end
    end

    assign in_ready_o  = w_adv[0] & ~rst_i & ~flush_i;
    assign out_valid_o = r_vld[STAGES-1];
    assign posit_o     = r_dat[STAGES-1];
    assign tag_o       = r_tag[STAGES-1];
`ifdef POSIT_SGNJ_FLAGS_EN
    assign flags_o     = r_flg[STAGES-1];
`endif

endmodule

// File: tb/tb_posit_sign_inject_pipe.sv
// Bench for posit_sign_inject_pipe: STAGES=1,2,3 instances, directed
// cases plus randomized traffic against a queue-based reference model.
module tb_posit_sign_inject_pipe;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v    [N];
    logic        fl   [N];
    logic        ordy [N];
    logic        irdy [N];
    logic        ovld [N];
    logic [31:0] a_s  [N];
    logic [31:0] b_s  [N];
    logic [31:0] po   [N];
    logic [1:0]  op_s [N];
    logic [3:0]  tg   [N];
    logic [3:0]  to   [N];
`ifdef POSIT_SGNJ_FLAGS_EN
    logic [1:0]  fo   [N];
`endif

    for (genvar g = 0; g < N; g++) begin : g_dut
        posit_sign_inject_pipe #(
            .WIDTH(32), .STAGES(g + 1), .TAG_WIDTH(4)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .flush_i    (fl[g]),
            .in_valid_i (v[g]),
            .in_ready_o (irdy[g]),
            .posit_a_i  (a_s[g]),
            .posit_b_i  (b_s[g]),
            .op_i       (op_s[g]),
            .tag_i      (tg[g]),
            .out_valid_o(ovld[g]),
            .out_ready_i(ordy[g]),
            .posit_o    (po[g]),
`ifdef POSIT_SGNJ_FLAGS_EN
            .flags_o    (fo[g]),
`endif
            .tag_o      (to[g])
        );
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference: {flags[1:0], tag, result}; negation as 2^32 - a.
    function automatic logic [37:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [1:0] op,
                                          input logic [3:0] t);
        logic  nar, zero, sa, sb, ts, flip;
        logic [32:0] m;
        logic [31:0] r;
        nar  = (a == 32'h8000_0000);
        zero = (a == 32'h0);
        sa   = (a >= 32'h8000_0000);
        sb   = (b >= 32'h8000_0000);
        case (op)
            2'd0:    ts = sb;
            2'd1:    ts = !sb;
            2'd2:    ts = (sa != sb);
            default: ts = sa;
        endcase
        flip = !(zero || nar) && (sa != ts);
        m = 33'h1_0000_0000 - {1'b0, a};
        r = flip ? m[31:0] : a;
        return {flip, nar, t, r};
    endfunction

    logic [37:0] q   [N][$];
    logic        acc [N];
    logic        pst [N];
    logic [31:0] ppo [N];
    logic [3:0]  pto [N];

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                q[i].delete();
                acc[i] = 1'b0;
                pst[i] = 1'b0;
            end else if (fl[i]) begin
                check("flush_rdy", 64'(irdy[i]), 64'd0);
                q[i].delete();
                acc[i] = 1'b0;
                pst[i] = 1'b0;
            end else begin
                if (pst[i]) begin
                    check("stall_vld", 64'(ovld[i]), 64'd1);
                    check("stall_dat", 64'(po[i]), 64'(ppo[i]));
                    check("stall_tag", 64'(to[i]), 64'(pto[i]));
                end
                if (ovld[i] && ordy[i]) begin
                    check("out_extra", 64'(q[i].size() != 0), 64'd1);
                    if (q[i].size() != 0) begin
                        logic [37:0] e;
                        e = q[i].pop_front();
                        check("out_dat", 64'(po[i]), 64'(e[31:0]));
                        check("out_tag", 64'(to[i]), 64'(e[35:32]));
`ifdef POSIT_SGNJ_FLAGS_EN
                        check("out_flg", 64'(fo[i]), 64'(e[37:36]));
`endif
                    end
                end
                acc[i] = v[i] && irdy[i];
                if (acc[i])
                    q[i].push_back(model(a_s[i], b_s[i], op_s[i], tg[i]));
                pst[i] = ovld[i] && !ordy[i];
                ppo[i] = po[i];
                pto[i] = to[i];
            end
        end
    end

    task automatic offer(input int i, input logic [3:0] t);
        v[i] = 1'b1;
        case ($urandom_range(0, 5))
            0:       a_s[i] = 32'h0000_0000;
            1:       a_s[i] = 32'h8000_0000;
            2:       a_s[i] = 32'h0000_0001;
            3:       a_s[i] = 32'hFFFF_FFFF;
            default: a_s[i] = $urandom;
        endcase
        b_s[i]  = $urandom;
        op_s[i] = 2'($urandom_range(0, 3));
        tg[i]   = t;
    endtask

    localparam int ND = 11;
    localparam logic [31:0] TA [ND] = '{
        32'h4000_0000, 32'hC000_0000, 32'hC000_0000, 32'h0000_0001,
        32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
        32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic [31:0] TB [ND] = '{
        32'h4000_0000, 32'h0000_0000, 32'hC000_0000, 32'h1234_5678,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
    localparam logic [1:0] TO [ND] = '{
        2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0};
    localparam logic [31:0] TR [ND] = '{
        32'hC000_0000, 32'h4000_0000, 32'h4000_0000, 32'h0000_0001,
        32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
        32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic [1:0] TF [ND] = '{
        2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b01, 2'b01,
        2'b01, 2'b00, 2'b00};

    logic [37:0] ex [8];
    int n;

    initial begin
        for (int i = 0; i < N; i++) begin
            v[i] = 0; fl[i] = 0; ordy[i] = 1; a_s[i] = 0;
            b_s[i] = 0; op_s[i] = 0; tg[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check("rst_vld", 64'(ovld[i]), 64'd0);
            check("rst_dat", 64'(po[i]), 64'd0);
            check("rst_tag", 64'(to[i]), 64'd0);
            check("rst_rdy", 64'(irdy[i]), 64'd0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_rdy", 64'(irdy[0]), 64'd1);

        // Directed single ops, STAGES=1: result one cycle after acceptance.
        for (int j = 0; j < ND; j++) begin
            @(posedge clk); #1;
            v[0] = 1; a_s[0] = TA[j]; b_s[0] = TB[j];
            op_s[0] = TO[j]; tg[0] = 4'(j);
            #1 check("dir_rdy", 64'(irdy[0]), 64'd1);
            @(posedge clk); #1;
            v[0] = 0;
            check("dir_vld", 64'(ovld[0]), 64'd1);
            check("dir_dat", 64'(po[0]), 64'(TR[j]));
            check("dir_tag", 64'(to[0]), 64'(j));
`ifdef POSIT_SGNJ_FLAGS_EN
            check("dir_flg", 64'(fo[0]), 64'(TF[j]));
`endif
        end

        // STAGES=3 back-to-back stream, tags 0..7.
        @(posedge clk); #1;
        offer(2, 4'd0);
        ex[0] = model(a_s[2], b_s[2], op_s[2], 4'd0);
        for (int k = 1; k < 12; k++) begin
            @(posedge clk); #1;
            if (k >= 3 && k <= 10) begin
                check("s3_vld", 64'(ovld[2]), 64'd1);
                check("s3_tag", 64'(to[2]), 64'(ex[k-3][35:32]));
                check("s3_dat", 64'(po[2]), 64'(ex[k-3][31:0]));
            end else begin
                check("s3_idle", 64'(ovld[2]), 64'd0);
            end
            if (k < 8) begin
                offer(2, 4'(k));
                ex[k] = model(a_s[2], b_s[2], op_s[2], 4'(k));
                #1 check("s3_rdy", 64'(irdy[2]), 64'd1);
            end else begin
                v[2] = 0;
            end
        end

        // Stall: hold out_ready low, then release; no loss or duplication.
        ordy[2] = 0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (v[2] && acc[2]) n++;
            if (c == 8) begin
                check("full_rdy", 64'(irdy[2]), 64'd0);
                check("full_vld", 64'(ovld[2]), 64'd1);
                check("full_tag", 64'(to[2]), 64'd8);
                ordy[2] = 1;
            end
            if (!(v[2] && !acc[2])) begin
                if (n < 4) offer(2, 4'(8 + n));
                else v[2] = 0;
            end
        end
        check("stall_acc", 64'(n), 64'd4);
        check("stall_drain", 64'(q[2].size()), 64'd0);

        // Flush on STAGES=2 with two in flight and one offered.
        ordy[1] = 0;
        @(posedge clk); #1; offer(1, 4'd1);
        @(posedge clk); #1; offer(1, 4'd2);
        @(posedge clk); #1; offer(1, 4'd3); fl[1] = 1;
        #1 check("fl_rdy", 64'(irdy[1]), 64'd0);
        @(posedge clk); #1;
        fl[1] = 0; v[1] = 0;
        check("fl_vld", 64'(ovld[1]), 64'd0);
        ordy[1] = 1;
        repeat (3) begin
            @(posedge clk); #1;
            check("fl_empty", 64'(ovld[1]), 64'd0);
        end
        offer(1, 4'd9);
        @(posedge clk); #1;
        v[1] = 0;
        check("t9_lat1", 64'(ovld[1]), 64'd0);
        @(posedge clk); #1;
        check("t9_vld", 64'(ovld[1]), 64'd1);
        check("t9_tag", 64'(to[1]), 64'd9);
        @(posedge clk); #1;
        check("t9_alone", 64'(ovld[1]), 64'd0);

        // Reset while STAGES=3 is full and stalled.
        ordy[2] = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (!(v[2] && !acc[2])) offer(2, 4'(c));
        end
        check("rf_rdy", 64'(irdy[2]), 64'd0);
        check("rf_vld", 64'(ovld[2]), 64'd1);
        rst = 1;
        #1 check("rs_rdy", 64'(irdy[2]), 64'd0);
        @(posedge clk); #1;
        check("rs_vld", 64'(ovld[2]), 64'd0);
        check("rs_dat", 64'(po[2]), 64'd0);
        check("rs_tag", 64'(to[2]), 64'd0);
        rst = 0; v[2] = 0; ordy[2] = 1;
        #1 check("rs_rdy_after", 64'(irdy[2]), 64'd1);

        // Randomized traffic with backpressure and occasional flush.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (!(v[i] && !acc[i])) begin
                    if ($urandom_range(0, 3) != 0)
                        offer(i, 4'($urandom_range(0, 15)));
                    else
                        v[i] = 0;
                end
                ordy[i] = ($urandom_range(0, 3) != 0);
                fl[i]   = ($urandom_range(0, 63) == 0);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            v[i] = 0; fl[i] = 0; ordy[i] = 1;
        end
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check("rand_drain", 64'(q[i].size()), 64'd0);
            check("rand_idle", 64'(ovld[i]), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
